// File: rtl/nrisc_pkg.sv
// Shared nRISC definitions: datapath width, reset PC, fetch FSM states and next-PC actions.
package nrisc_pkg;

  localparam int unsigned LARGURA_NRISC = 8;
  localparam logic [LARGURA_NRISC-1:0] PC_RESET = 8'h00;

  typedef enum logic [1:0] {
    ESTADO_INICIO = 2'd0,
    ESTADO_BUSCA  = 2'd1,
    ESTADO_PARADO = 2'd2
  } estado_e;

  // What the fetch stage does on the coming edge; chosen by proximo_pc.
  typedef enum logic [2:0] {
    ACAO_MANTER = 3'd0,
    ACAO_SEQ    = 3'd1,
    ACAO_SALTO  = 3'd2,
    ACAO_DESVIO = 3'd3,
    ACAO_PARAR  = 3'd4
  } acao_e;

endpackage

// File: rtl/proximo_pc.sv
// Combinational next-PC selection: halt > jump > branch > sequential, all modulo 2^LARGURA.
module proximo_pc
  import nrisc_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_NRISC
) (
  input  estado_e              estado_i,
  input  logic                 habilita_i,
  input  logic                 valida_i,
  input  logic                 parar_i,
  input  logic                 salto_i,
  input  logic                 desvio_i,
  input  logic                 continuar_i,
  input  logic [LARGURA-1:0]   pc_i,
  input  logic [LARGURA-1:0]   pc_instrucao_i,
  input  logic [LARGURA-1:0]   alvo_salto_i,
  input  logic [LARGURA-1:0]   deslocamento_i,
  output acao_e                acao_c,
  output logic [LARGURA-1:0]   proximo_c
);

  always_comb begin
    acao_c    = ACAO_MANTER;
    proximo_c = pc_i;
    if (habilita_i) begin
      case (estado_i)
        ESTADO_BUSCA: begin
          // Redirects only apply to a real instruction sitting in the register.
          if (valida_i && parar_i) begin
            acao_c = ACAO_PARAR;
          end else if (valida_i && salto_i) begin
            acao_c    = ACAO_SALTO;
            proximo_c = alvo_salto_i;
          end else if (valida_i && desvio_i) begin
            acao_c    = ACAO_DESVIO;
            proximo_c = pc_instrucao_i + deslocamento_i;
          end else begin
            acao_c    = ACAO_SEQ;
            proximo_c = pc_i + LARGURA'(1);
          end
        end
        ESTADO_PARADO: begin
          if (continuar_i) begin
            acao_c    = ACAO_SEQ;
            proximo_c = pc_i + LARGURA'(1);
          end
        end
        default: begin
          acao_c    = ACAO_MANTER;
          proximo_c = pc_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// nRISC instruction fetch stage: owns the PC, captures memory bytes into the instruction register.
module unidade_busca
  import nrisc_pkg::*;
#(
  parameter int unsigned         LARGURA          = LARGURA_NRISC,
  parameter logic [LARGURA-1:0]  ENDERECO_INICIAL = PC_RESET
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                habilita,
  input  logic                salto,
  input  logic [LARGURA-1:0]  alvo_salto,
  input  logic                desvio,
  input  logic [LARGURA-1:0]  deslocamento,
  input  logic                parar,
  input  logic                continuar,
  input  logic [LARGURA-1:0]  instrucao_entrada,
  output logic [LARGURA-1:0]  endereco,
  output logic [LARGURA-1:0]  instrucao,
  output logic [LARGURA-1:0]  pc_instrucao,
  output logic                valida,
  output logic                parado
);

  estado_e              estado_q, estado_d;
  logic [LARGURA-1:0]   endereco_q, endereco_d;
  logic [LARGURA-1:0]   instrucao_q, instrucao_d;
  logic [LARGURA-1:0]   pc_instrucao_q, pc_instrucao_d;
  logic                 valida_q, valida_d;
  logic                 parado_q, parado_d;
  acao_e                acao_c;
  logic [LARGURA-1:0]   proximo_c;

  proximo_pc #(.LARGURA(LARGURA)) u_proximo_pc (
    .estado_i       (estado_q),
    .habilita_i     (habilita),
    .valida_i       (valida_q),
    .parar_i        (parar),
    .salto_i        (salto),
    .desvio_i       (desvio),
    .continuar_i    (continuar),
    .pc_i           (endereco_q),
    .pc_instrucao_i (pc_instrucao_q),
    .alvo_salto_i   (alvo_salto),
    .deslocamento_i (deslocamento),
    .acao_c         (acao_c),
    .proximo_c      (proximo_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q       <= ESTADO_INICIO;
      endereco_q     <= ENDERECO_INICIAL;
      instrucao_q    <= '0;
      pc_instrucao_q <= '0;
      valida_q       <= 1'b0;
      parado_q       <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      endereco_q     <= endereco_d;
      instrucao_q    <= instrucao_d;
      pc_instrucao_q <= pc_instrucao_d;
      valida_q       <= valida_d;
      parado_q       <= parado_d;
    end
  end

  always_comb begin
    estado_d       = estado_q;
    endereco_d     = endereco_q;
    instrucao_d    = instrucao_q;
    pc_instrucao_d = pc_instrucao_q;
    valida_d       = valida_q;
    parado_d       = parado_q;
    if (habilita) begin
      endereco_d = proximo_c;
      case (estado_q)
        ESTADO_INICIO: begin
          estado_d = ESTADO_BUSCA;
          valida_d = 1'b0;
        end
        ESTADO_BUSCA: begin
          if (acao_c == ACAO_SEQ) begin
            instrucao_d    = instrucao_entrada;
            pc_instrucao_d = endereco_q;
            valida_d       = 1'b1;
          end else begin
            valida_d = 1'b0;
          end
          if (acao_c == ACAO_PARAR) begin
            estado_d = ESTADO_PARADO;
            parado_d = 1'b1;
          end
        end
        ESTADO_PARADO: begin
          // Memory already presents mem[PC], so resuming captures on the same edge.
          if (acao_c == ACAO_SEQ) begin
            instrucao_d    = instrucao_entrada;
            pc_instrucao_d = endereco_q;
            valida_d       = 1'b1;
            estado_d       = ESTADO_BUSCA;
            parado_d       = 1'b0;
          end
        end
        default: begin
          estado_d = ESTADO_INICIO;
          valida_d = 1'b0;
          parado_d = 1'b0;
        end
      endcase
    end
  end

  assign endereco     = endereco_q;
  assign instrucao    = instrucao_q;
  assign pc_instrucao = pc_instrucao_q;
  assign valida       = valida_q;
  assign parado       = parado_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed bench for unidade_busca with a negedge-sampled memory holding mem[i] = i ^ 8'hA5.
module tb_unidade_busca;

  logic       clk;
  logic       reset;
  logic       habilita;
  logic       salto;
  logic [7:0] alvo_salto;
  logic       desvio;
  logic [7:0] deslocamento;
  logic       parar;
  logic       continuar;
  logic [7:0] instrucao_entrada;
  logic [7:0] endereco;
  logic [7:0] instrucao;
  logic [7:0] pc_instrucao;
  logic       valida;
  logic       parado;

  int n_vec = 0;
  int n_mis = 0;

  unidade_busca #(.LARGURA(8), .ENDERECO_INICIAL(8'h00)) dut (
    .clk               (clk),
    .reset             (reset),
    .habilita          (habilita),
    .salto             (salto),
    .alvo_salto        (alvo_salto),
    .desvio            (desvio),
    .deslocamento      (deslocamento),
    .parar             (parar),
    .continuar         (continuar),
    .instrucao_entrada (instrucao_entrada),
    .endereco          (endereco),
    .instrucao         (instrucao),
    .pc_instrucao      (pc_instrucao),
    .valida            (valida),
    .parado            (parado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) instrucao_entrada <= endereco ^ 8'hA5;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_saida(input string tag, input logic [7:0] e_end, input logic [7:0] e_ins,
                           input logic [7:0] e_pc, input logic e_val, input logic e_par);
    chk({tag, ".endereco"}, endereco, e_end);
    chk({tag, ".instrucao"}, instrucao, e_ins);
    chk({tag, ".pc_instrucao"}, pc_instrucao, e_pc);
    chk({tag, ".valida"}, 8'(valida), 8'(e_val));
    chk({tag, ".parado"}, 8'(parado), 8'(e_par));
  endtask

  initial begin
    reset = 1'b0; habilita = 1'b1; salto = 1'b0; alvo_salto = 8'h00;
    desvio = 1'b0; deslocamento = 8'h00; parar = 1'b0; continuar = 1'b0;
    instrucao_entrada = 8'h00;

    // Reset values and startup timing
    #12;
    chk_saida("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_saida("inicio", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    chk_saida("primeira", 8'h01, 8'hA5, 8'h00, 1'b1, 1'b0);
    tick();
    chk_saida("segunda", 8'h02, 8'hA4, 8'h01, 1'b1, 1'b0);
    repeat (4) tick();
    chk_saida("seq5", 8'h06, 8'hA0, 8'h05, 1'b1, 1'b0);

    // Jump held for two edges: the second one lands on the bubble and must be ignored
    salto = 1'b1; alvo_salto = 8'h40;
    tick();
    chk_saida("salto_bolha", 8'h40, 8'hA0, 8'h05, 1'b0, 1'b0);
    tick();
    salto = 1'b0;
    chk_saida("salto_alvo", 8'h41, 8'hE5, 8'h40, 1'b1, 1'b0);

    salto = 1'b1; alvo_salto = 8'h02;
    tick();
    salto = 1'b0;
    chk("salto2_bolha", 8'(valida), 8'h00);
    tick();
    chk_saida("salto2_alvo", 8'h03, 8'hA7, 8'h02, 1'b1, 1'b0);

    // Backward branch -4 from 0x02 wraps to 0xFE, then PC wraps through 0xFF
    desvio = 1'b1; deslocamento = 8'hFC;
    tick();
    desvio = 1'b0;
    chk_saida("desvio_bolha", 8'hFE, 8'hA7, 8'h02, 1'b0, 1'b0);
    tick();
    chk_saida("desvio_FE", 8'hFF, 8'h5B, 8'hFE, 1'b1, 1'b0);
    tick();
    chk_saida("seq_FF", 8'h00, 8'h5A, 8'hFF, 1'b1, 1'b0);
    tick();
    chk_saida("seq_00", 8'h01, 8'hA5, 8'h00, 1'b1, 1'b0);

    // Halt wins over simultaneous jump and branch
    parar = 1'b1; salto = 1'b1; alvo_salto = 8'h80; desvio = 1'b1; deslocamento = 8'h10;
    tick();
    parar = 1'b0; salto = 1'b0; desvio = 1'b0;
    chk_saida("parar", 8'h01, 8'hA5, 8'h00, 1'b0, 1'b1);
    tick();
    tick();
    chk_saida("parado", 8'h01, 8'hA5, 8'h00, 1'b0, 1'b1);
    continuar = 1'b1;
    tick();
    continuar = 1'b0;
    chk_saida("continuar", 8'h02, 8'hA4, 8'h01, 1'b1, 1'b0);

    // Stall with a branch pulse that must be ignored
    habilita = 1'b0;
    tick();
    desvio = 1'b1; deslocamento = 8'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_saida("congelado", 8'h02, 8'hA4, 8'h01, 1'b1, 1'b0);
    end
    desvio = 1'b0; habilita = 1'b1;
    tick();
    chk_saida("retoma", 8'h03, 8'hA7, 8'h02, 1'b1, 1'b0);
    tick();
    chk_saida("retoma2", 8'h04, 8'hA6, 8'h03, 1'b1, 1'b0);

    // Asynchronous reset between edges, then the same restart timing
    #3;
    reset = 1'b0;
    #1;
    chk_saida("reset_async", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_saida("reinicio", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    chk_saida("reinicio_primeira", 8'h01, 8'hA5, 8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch stage of the 8-bit nRISC core, directly upstream of the instruction memory. Owns the program counter, drives the memory address, and registers the returned byte into an instruction register with its PC and a valid flag for the decoder. Handles sequential fetch, absolute jumps, PC-relative branches, pipeline stalls and a halt/resume state. Every redirect costs one bubble.

## Interface
- `LARGURA`, 8, address and instruction width (fixed at 8 for nRISC).
- `ENDERECO_INICIAL`, 8'h00, PC value after reset.

- `clk`  in  1  single clock. All state updates happen on posedge. The instruction memory samples `endereco` on negedge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `habilita`  in  1  1 = stage advances; 0 = full freeze, and redirect/halt inputs are ignored.
- `salto`  in  1  absolute jump request for the instruction currently in `instrucao`.
- `alvo_salto`  in  8  jump target.
- `desvio`  in  1  taken-branch request for the instruction currently in `instrucao`.
- `deslocamento`  in  8  signed two's-complement branch offset.
- `parar`  in  1  halt request (decoded HALT).
- `continuar`  in  1  resume request; honoured only in PARADO.
- `instrucao_entrada`  in  8  byte from instruction memory.
- `endereco`  out  8  PC driven to instruction memory.
- `instrucao`  out  8  registered instruction.
- `pc_instrucao`  out  8  address the held instruction was fetched from.
- `valida`  out  1  `instrucao` is a real instruction.
- `parado`  out  1  1 while in PARADO.

## Operation
- FSM states:
  - INICIO: PC is held and `valida`=0. This guarantees one negedge read of `endereco` before the first capture. Next state is always BUSCA.
  - BUSCA: normal fetch.
  - PARADO: halted.
- BUSCA with `habilita`=1 and no accepted request: `instrucao`<=`instrucao_entrada`, `pc_instrucao`<=`endereco`, `valida`<=1, `endereco`<=`endereco`+1.
- A request is accepted only in BUSCA with `habilita`=1 and `valida`=1. Requests arriving while `valida`=0 are ignored.
- Priority of accepted requests: `parar` > `salto` > `desvio`.
  - `parar`: `valida`<=0, PC held, next state PARADO.
  - `salto`: `endereco`<=`alvo_salto`, `valida`<=0. The fall-through byte is discarded.
  - `desvio`: `endereco`<=`pc_instrucao`+`deslocamento` (8-bit, modulo 256), `valida`<=0.
- PARADO: `parado`=1, `valida`=0, PC held. When `continuar`=1 at a posedge, that same edge captures `instrucao_entrada` (already mem[PC]), sets `valida`<=1, increments the PC, and moves to BUSCA.
- `habilita`=0 in any state freezes PC, `instrucao`, `pc_instrucao`, `valida` and the state. `continuar` is also ignored while `habilita`=0.
- Arithmetic: PC increment wraps 8'hFF -> 8'h00. Branch offsets of -128..+127 wrap modulo 256.
- Reset values, applied asynchronously on `reset`=0 (including mid-operation):
  - `endereco`=`ENDERECO_INICIAL`
  - `instrucao`=8'h00, `pc_instrucao`=8'h00
  - `valida`=0, `parado`=0
  - state INICIO

## Timing
- Fetch latency: PC p presented at posedge N is read by memory at the following negedge and captured at posedge N+1. `instrucao` is valid one cycle after `endereco`=p.
- Throughput: one instruction per cycle in steady state.
- After reset deassertion: the first posedge performs INICIO -> BUSCA. The second posedge captures mem[`ENDERECO_INICIAL`] with `valida`=1.
- Redirect accepted at posedge N: `valida`=0 for cycle N..N+1, and the target instruction has `valida`=1 after posedge N+1 (exactly one bubble).
- Halt accepted at posedge N: `parado`=1 from N. With `continuar` high at posedge M, `valida`=1 and `parado`=0 after posedge M.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `nrisc_pkg`:
  - `LARGURA_NRISC`=8
  - FSM state encoding `ESTADO_INICIO`/`ESTADO_BUSCA`/`ESTADO_PARADO`
  - reset PC constant
- Sub-module `proximo_pc`: combinational next-PC mux with the priority and modulo arithmetic above, instantiated once.
- The FSM and registers stay in `unidade_busca`.

## Test plan
- Reset release with memory mem[i]=i^8'hA5 -> first `valida`=1 shows `instrucao`=8'hA5, `pc_instrucao`=8'h00. Next cycle shows 8'hA4, `pc_instrucao`=8'h01.
- `salto`=1, `alvo_salto`=8'h40 while `instrucao` is from PC 8'h05 -> exactly one cycle with `valida`=0, then `pc_instrucao`=8'h40, `instrucao`=8'hE5.
- `desvio`=1, `deslocamento`=8'hFC at `pc_instrucao`=8'h02 -> target 8'hFE, then sequential fetch 8'hFF, 8'h00 (wrap).
- Simultaneous `parar`, `salto`, `desvio` -> `parado`=1, PC unchanged. `continuar` 3 cycles later -> resumes at the held PC with no lost or duplicated byte.
- `habilita`=0 for 4 cycles mid-stream, with `desvio` pulsed while stalled -> all outputs constant and the branch ignored. Resumes at the next sequential PC.
- `reset` driven to 0 between edges mid-stream -> outputs go to reset values immediately, without waiting for a clock edge. Restart timing matches the first scenario.
